// File: rtl/clz_normalize_pipe.sv
// clz_normalize_pipe: two-stage normaliser that counts leading zeros, left-shifts the
// word so its MSB is set, and reports the shift count and an all-zero flag.
// Stage 1 registers the word with its leading-zero count; stage 2 registers the shifted
// word and drives the outputs. Both stages use a valid/ready handshake with no skid buffer.
// Optional feature: define CLZ_NORM_EXP_EN to carry an exponent alongside the data and
// emit exponent - count, saturated at zero, with an underflow flag.
module clz_normalize_pipe #(
    parameter int WIDTH = 16
`ifdef CLZ_NORM_EXP_EN
    ,
    parameter int EXP_W = 8
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
`ifdef CLZ_NORM_EXP_EN
    input  logic [EXP_W-1:0]           in_exp,
    output logic [EXP_W-1:0]           out_exp,
    output logic                       out_uflow,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(WIDTH):0]     out_cnt,
    output logic                       out_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // Leading-zero count; the highest set bit wins, an all-zero word yields WIDTH.
    function automatic logic [CNT_W-1:0] clz_f(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                c = CNT_W'(WIDTH - 1 - i);
            end
        end
        return c;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic [CNT_W-1:0] s1_cnt_q, s1_cnt_d;
    logic             s1_zero_q, s1_zero_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    logic [CNT_W-1:0] s2_cnt_q, s2_cnt_d;
    logic             s2_zero_q, s2_zero_d;

`ifdef CLZ_NORM_EXP_EN
    localparam int CMP_W = (EXP_W > CNT_W) ? EXP_W : CNT_W;

    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
    logic             s2_uflow_q, s2_uflow_d;
    logic [CMP_W-1:0] exp_ext;
    logic [CMP_W-1:0] cnt_ext;
`else
    // Exponent path absent: no sideband state is carried through the pipe.
`endif

    logic s1_adv;
    logic s2_adv;

    // Advance conditions: a stage may load when it is empty or its contents move on.
    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;
    end

    // Stage 1 next state: capture the incoming word with its count and zero flag.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_cnt_d   = s1_cnt_q;
        s1_zero_d  = s1_zero_q;
`ifdef CLZ_NORM_EXP_EN
        s1_exp_d   = s1_exp_q;
`endif
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = in_data;
                s1_cnt_d  = clz_f(in_data);
                s1_zero_d = (in_data == '0);
`ifdef CLZ_NORM_EXP_EN
                s1_exp_d  = in_exp;
`endif
            end
        end
    end

    // Stage 2 next state: shift the word by its count (a shift by WIDTH gives zero).
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_cnt_d   = s2_cnt_q;
        s2_zero_d  = s2_zero_q;
`ifdef CLZ_NORM_EXP_EN
        s2_exp_d   = s2_exp_q;
        s2_uflow_d = s2_uflow_q;
        exp_ext    = CMP_W'(s1_exp_q);
        cnt_ext    = CMP_W'(s1_cnt_q);
`endif
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = s1_data_q << s1_cnt_q;
                s2_cnt_d  = s1_cnt_q;
                s2_zero_d = s1_zero_q;
`ifdef CLZ_NORM_EXP_EN
                if (s1_zero_q) begin
                    s2_exp_d   = '0;
                    s2_uflow_d = 1'b0;
                end else if (exp_ext < cnt_ext) begin
                    s2_exp_d   = '0;
                    s2_uflow_d = 1'b1;
                end else begin
                    s2_exp_d   = EXP_W'(exp_ext - cnt_ext);
                    s2_uflow_d = 1'b0;
                end
`endif
            end
        end
    end

    // Pipeline registers with synchronous active-low reset clearing all state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_cnt_q   <= '0;
            s1_zero_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_cnt_q   <= '0;
            s2_zero_q  <= 1'b0;
`ifdef CLZ_NORM_EXP_EN
            s1_exp_q   <= '0;
            s2_exp_q   <= '0;
            s2_uflow_q <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_cnt_q   <= s1_cnt_d;
            s1_zero_q  <= s1_zero_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_cnt_q   <= s2_cnt_d;
            s2_zero_q  <= s2_zero_d;
`ifdef CLZ_NORM_EXP_EN
            s1_exp_q   <= s1_exp_d;
            s2_exp_q   <= s2_exp_d;
            s2_uflow_q <= s2_uflow_d;
`endif
        end
    end

    // Stage 2 registers drive the outputs directly.
    always_comb begin
        out_valid = s2_valid_q;
        out_data  = s2_data_q;
        out_cnt   = s2_cnt_q;
        out_zero  = s2_zero_q;
`ifdef CLZ_NORM_EXP_EN
        out_exp   = s2_exp_q;
        out_uflow = s2_uflow_q;
`endif
    end

endmodule

// File: tb/tb_clz_normalize_pipe.sv
// Testbench for clz_normalize_pipe (WIDTH = 16).
// Expected results come from an arithmetic normalisation model and flow through a
// scoreboard queue; a negedge monitor pops and compares whenever the DUT hands off a word.
module tb_clz_normalize_pipe;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] data;
        int           cnt;
        bit           zero;
        int           exp;
        bit           uflow;
        int           acc_cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [7:0]   in_exp;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [4:0]   out_cnt;
    logic         out_zero;
`ifdef CLZ_NORM_EXP_EN
    logic [7:0]   out_exp;
    logic         out_uflow;
`endif

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_low = -1;
    int   acc_count = 0;
    bit   rand_ready = 0;
    bit   ready_force = 1;

    clz_normalize_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef CLZ_NORM_EXP_EN
        .in_exp    (in_exp),
        .out_exp   (out_exp),
        .out_uflow (out_uflow),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: either forced by the sequence or randomised per cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Reference model: normalise by repeated doubling until the top bit is set.
    function automatic exp_t refModel(input logic [W-1:0] d, input int e);
        exp_t r;
        int unsigned x;
        x = d;
        r.cnt = 0;
        r.zero = (d == 0);
        if (x == 0) begin
            r.cnt = W;
        end else begin
            while (x < (1 << (W - 1))) begin
                x = x * 2;
                r.cnt++;
            end
        end
        r.data = x[W-1:0];
        if (r.zero) begin
            r.exp = 0;
            r.uflow = 0;
        end else if (e < r.cnt) begin
            r.exp = 0;
            r.uflow = 1;
        end else begin
            r.exp = e - r.cnt;
            r.uflow = 0;
        end
        r.acc_cyc = 0;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive one word and wait (bounded) for it to be accepted; push its expectation.
    task automatic applyStimulus(input logic [W-1:0] d, input logic [7:0] e);
        exp_t r;
        bit   done;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        in_exp   = e;
        done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (in_ready && rst_n) begin
                r = refModel(d, int'(e));
                r.acc_cyc = cyc;
                sb.push_back(r);
                acc_count++;
                done = 1;
            end
        end
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    // Monitor: compare each handed-off word against the queue head; check hold while stalled.
    logic [W-1:0] held_data;
    logic [4:0]   held_cnt;
    logic         held_zero;
    bit           prev_stall = 0;
    always @(negedge clk) begin
        exp_t r;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_data", 32'(out_data), 32'(held_data));
                checkOutput("hold_cnt", 32'(out_cnt), 32'(held_cnt));
                checkOutput("hold_zero", 32'(out_zero), 32'(held_zero));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_word", 32'(out_data), 32'hDEAD);
                end else begin
                    r = sb.pop_front();
                    checkOutput("out_data", 32'(out_data), 32'(r.data));
                    checkOutput("out_cnt", 32'(out_cnt), 32'(r.cnt));
                    checkOutput("out_zero", 32'(out_zero), 32'(r.zero));
`ifdef CLZ_NORM_EXP_EN
                    checkOutput("out_exp", 32'(out_exp), 32'(r.exp));
                    checkOutput("out_uflow", 32'(out_uflow), 32'(r.uflow));
`endif
                    if (last_low < r.acc_cyc + 1)
                        checkOutput("latency", 32'(cyc - r.acc_cyc), 32'd2);
                end
            end
            if (!out_ready) last_low = cyc;
            prev_stall = out_valid && !out_ready;
            held_data = out_data;
            held_cnt  = out_cnt;
            held_zero = out_zero;
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_exp   = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_cnt", 32'(out_cnt), 32'd0);
        checkOutput("rst_out_zero", 32'(out_zero), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] directed words, out_ready high");
        applyStimulus(16'h0001, 8'd0);
        applyStimulus(16'h0000, 8'd3);
        applyStimulus(16'h8000, 8'd7);
        applyStimulus(16'h0F00, 8'd9);
        applyStimulus(16'h00F0, 8'd9);
        applyStimulus(16'h000F, 8'd9);
        applyStimulus(16'h3000, 8'd9);
        applyStimulus(16'h0010, 8'd20);
        applyStimulus(16'h0010, 8'd5);
        idle(5);

        $display("[TB] stall with out_ready low");
        ready_force = 0;
        @(posedge clk);
        #2;
        fork
            begin
                applyStimulus(16'h0F00, 8'd1);
                applyStimulus(16'h00F0, 8'd2);
                applyStimulus(16'h000F, 8'd30);
                applyStimulus(16'h3000, 8'd4);
            end
            begin
                int base;
                base = acc_count;
                repeat (5) @(negedge clk);
                #1;
                checkOutput("stall_accepts", 32'(acc_count - base), 32'd2);
                checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
                ready_force = 1;
            end
        join
        idle(6);
        checkOutput("stall_drained", 32'(sb.size()), 32'd0);

        $display("[TB] reset with words in flight");
        ready_force = 0;
        @(posedge clk);
        applyStimulus(16'h1234, 8'd8);
        applyStimulus(16'h0042, 8'd8);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_force = 1;
        repeat (6) @(posedge clk);

        $display("[TB] randomised traffic");
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] d;
            logic [31:0]  raw;
            raw = $urandom;
            d = W'(raw >> $urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) d = '0;
            applyStimulus(d, 8'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        rand_ready = 0;
        ready_force = 1;
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        checkOutput("final_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
